// File: rtl/decode_pkg.sv
// Shared field layout, decoded-instruction record and stage state for the
// multi-issue decode stage.
package decode_pkg;

    localparam int FLD_OP_W  = 4;
    localparam int FLD_REG_W = 4;
    localparam int FLD_IMM_W = 5;

    localparam int OP_LSB  = 28;
    localparam int DES_LSB = 24;
    localparam int S1_LSB  = 20;
    localparam int S2_LSB  = 16;
    localparam int IME_LSB = 0;

    localparam logic [FLD_OP_W-1:0] OP_NOP = 4'h0;

    typedef struct packed {
        logic [FLD_OP_W-1:0]  op;
        logic [FLD_REG_W-1:0] des;
        logic [FLD_REG_W-1:0] s1;
        logic [FLD_REG_W-1:0] s2;
        logic [FLD_IMM_W-1:0] ime;
    } decoded_t;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_t;

endpackage

// File: rtl/decode_field.sv
// Combinational extraction of the decoded fields from one instruction word.
module decode_field
    import decode_pkg::*;
#(
    parameter int INSTR_W = 32
) (
    input  logic [INSTR_W-1:0] instr,
    output decoded_t           dec
);

    logic unused_s;

    // Slice the fixed field positions out of the instruction word.
    always_comb begin
        dec.op  = instr[OP_LSB  +: FLD_OP_W];
        dec.des = instr[DES_LSB +: FLD_REG_W];
        dec.s1  = instr[S1_LSB  +: FLD_REG_W];
        dec.s2  = instr[S2_LSB  +: FLD_REG_W];
        dec.ime = instr[IME_LSB +: FLD_IMM_W];
    end

    // Bits between the immediate and s2 carry no meaning for this stage.
    assign unused_s = ^{instr[S2_LSB-1:IME_LSB+FLD_IMM_W], instr[INSTR_W-1:OP_LSB+FLD_OP_W-1] & 1'b0};

endmodule

// File: rtl/decode_bundle.sv
// N-wide registered decode stage: holds one bundle and emits it as in-order
// issue groups that contain no intra-group RAW/WAW register dependency.
module decode_bundle
    import decode_pkg::*;
#(
    parameter int WIDTH   = 2,
    parameter int INSTR_W = 32,
    parameter int REG_W   = 4,
    parameter int IMM_W   = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH*INSTR_W-1:0] in_instr,
    input  logic [WIDTH-1:0]         in_mask,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_slot_valid,
    output logic [WIDTH*4-1:0]       out_op,
    output logic [WIDTH*4-1:0]       out_des,
    output logic [WIDTH*4-1:0]       out_s1,
    output logic [WIDTH*4-1:0]       out_s2,
    output logic [WIDTH*IMM_W-1:0]   out_ime,
    output logic                     out_last
);

    state_t                   state_r;
    state_t                   state_nxt_s;
    logic [WIDTH*INSTR_W-1:0] hold_instr_r;
    logic [WIDTH-1:0]         rem_mask_r;
    logic [WIDTH-1:0]         rem_nxt_s;
    logic [WIDTH-1:0]         group_s;
    decoded_t [WIDTH-1:0]     dec_s;
    logic                     out_fire_s;
    logic                     in_fire_s;

    // Lowest remaining slot always issues; later slots join until the first
    // one that reads or rewrites a register already written by the group.
    function automatic logic [WIDTH-1:0] form_group(input decoded_t [WIDTH-1:0] dec,
                                                    input logic [WIDTH-1:0] rem);
        logic [WIDTH-1:0]          grp;
        logic [2**FLD_REG_W-1:0]   wr;
        logic                      stop;
        grp  = '0;
        wr   = '0;
        stop = 1'b0;
        for (int j = 0; j < WIDTH; j++) begin
            if (rem[j] && !stop) begin
                if ((dec[j].op != OP_NOP) &&
                    (wr[dec[j].s1] || wr[dec[j].s2] || wr[dec[j].des])) begin
                    stop = 1'b1;
                end else begin
                    grp[j] = 1'b1;
                    if (dec[j].op != OP_NOP) begin
                        wr[dec[j].des] = 1'b1;
                    end else begin
                        wr = wr;
                    end
                end
            end else begin
                grp = grp;
            end
        end
        return grp;
    endfunction

    for (genvar g = 0; g < WIDTH; g++) begin : g_field
        decode_field #(.INSTR_W(INSTR_W)) u_field (
            .instr (hold_instr_r[g*INSTR_W +: INSTR_W]),
            .dec   (dec_s[g])
        );
    end

    assign group_s        = (state_r == HOLD) ? form_group(dec_s, rem_mask_r) : '0;
    assign out_valid      = (state_r == HOLD);
    assign out_slot_valid = group_s;
    assign out_last       = (state_r == HOLD) && (group_s == rem_mask_r);
    assign out_fire_s     = out_valid && out_ready;
    // Deliberate combinational path from out_ready for bubble-free bundles.
    assign in_ready       = !rst && ((state_r == EMPTY) || (out_fire_s && out_last));
    assign in_fire_s      = in_valid && in_ready;

    // Next remaining mask and state from the input and output handshakes.
    always_comb begin
        state_nxt_s = state_r;
        rem_nxt_s   = rem_mask_r;
        if (in_fire_s) begin
            rem_nxt_s   = in_mask;
            state_nxt_s = (in_mask != '0) ? HOLD : EMPTY;
        end else if (out_fire_s) begin
            rem_nxt_s   = rem_mask_r & ~group_s;
            state_nxt_s = (rem_nxt_s == '0) ? EMPTY : HOLD;
        end else begin
            state_nxt_s = state_r;
            rem_nxt_s   = rem_mask_r;
        end
    end

    // State, remaining mask and held bundle registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= EMPTY;
            rem_mask_r   <= '0;
            hold_instr_r <= '0;
        end else begin
            state_r    <= state_nxt_s;
            rem_mask_r <= rem_nxt_s;
            if (in_fire_s) begin
                hold_instr_r <= in_instr;
            end
        end
    end

    // Pack the decoded hold-register fields onto the flat output buses.
    always_comb begin
        out_op  = '0;
        out_des = '0;
        out_s1  = '0;
        out_s2  = '0;
        out_ime = '0;
        for (int i = 0; i < WIDTH; i++) begin
            out_op[i*4 +: 4]         = dec_s[i].op;
            out_des[i*4 +: 4]        = dec_s[i].des;
            out_s1[i*4 +: 4]         = dec_s[i].s1;
            out_s2[i*4 +: 4]         = dec_s[i].s2;
            out_ime[i*IMM_W +: IMM_W] = dec_s[i].ime[IMM_W-1:0];
        end
    end

endmodule

// File: tb/tb_decode_bundle.sv
// Self-checking bench for decode_bundle (4 slots): directed scenarios plus a
// randomized run against a group-splitting reference model.
module tb_decode_bundle;

    localparam int W = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [W*32-1:0] in_instr = '0;
    logic [W-1:0]    in_mask = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [W-1:0]    out_slot_valid;
    logic [W*4-1:0]  out_op, out_des, out_s1, out_s2;
    logic [W*5-1:0]  out_ime;
    logic            out_last;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    decode_bundle #(.WIDTH(W), .INSTR_W(32), .REG_W(4), .IMM_W(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_mask(in_mask), .out_valid(out_valid),
        .out_ready(out_ready), .out_slot_valid(out_slot_valid), .out_op(out_op),
        .out_des(out_des), .out_s1(out_s1), .out_s2(out_s2), .out_ime(out_ime),
        .out_last(out_last)
    );

    // Reference: split a bundle into groups using a list of written registers.
    function automatic void model_split(input logic [W*32-1:0] ins, input logic [W-1:0] mask);
        logic [W-1:0] rem, grp;
        logic [3:0]   op, des, s1, s2;
        int           dests[$];
        logic         hit;
        rem = mask;
        while (rem != '0) begin
            grp = '0;
            dests.delete();
            for (int j = 0; j < W; j++) begin
                if (rem[j]) begin
                    op  = ins[j*32+28 +: 4];
                    des = ins[j*32+24 +: 4];
                    s1  = ins[j*32+20 +: 4];
                    s2  = ins[j*32+16 +: 4];
                    hit = 1'b0;
                    if (op != 4'h0) begin
                        foreach (dests[k]) begin
                            if (dests[k] == int'(s1) || dests[k] == int'(s2) || dests[k] == int'(des)) hit = 1'b1;
                        end
                    end
                    if (hit) break;
                    grp[j] = 1'b1;
                    if (op != 4'h0) dests.push_back(int'(des));
                end
            end
            exp_q.push_back(grp);
            rem &= ~grp;
        end
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_in_rst got=%b exp=0", in_ready); end
        rst = 1'b0; #1;
        checks++; if ({out_valid, out_slot_valid, out_last} !== 6'b0) begin errors++; $display("FAIL reset_ctrl got=%b exp=0", {out_valid, out_slot_valid, out_last}); end
        checks++; if ({out_op, out_des, out_s1, out_s2, out_ime} !== '0) begin errors++; $display("FAIL reset_fields got=%h exp=0", {out_op, out_des, out_s1, out_s2, out_ime}); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_basic();
        @(negedge clk);
        in_valid = 1'b1; in_mask = 4'b0011; out_ready = 1'b1;
        in_instr = {64'h0, 32'h2456_0007, 32'h1312_0005}; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_accept got=%b exp=1", in_ready); end
        @(negedge clk); in_valid = 1'b0; #1;
        checks++; if ({out_valid, out_slot_valid, out_last} !== 6'b1_0011_1) begin errors++; $display("FAIL basic_group got=%b exp=100111", {out_valid, out_slot_valid, out_last}); end
        checks++; if ({out_op[7:0], out_des[7:0], out_ime[9:0]} !== {8'h21, 8'h43, 5'd7, 5'd5}) begin errors++; $display("FAIL basic_fields got=%h", {out_op[7:0], out_des[7:0], out_ime[9:0]}); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready got=%b exp=1", in_ready); end
        @(negedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_raw();
        @(negedge clk);
        in_valid = 1'b1; in_mask = 4'b0011; out_ready = 1'b1;
        in_instr = {64'h0, 32'h2536_0000, 32'h1312_0005}; #1;
        @(negedge clk); in_valid = 1'b0; #1;
        checks++; if ({out_valid, out_slot_valid, out_last, in_ready} !== 7'b1_0001_0_0) begin errors++; $display("FAIL raw_group0 got=%b exp=1000100", {out_valid, out_slot_valid, out_last, in_ready}); end
        @(negedge clk); #1;
        checks++; if ({out_valid, out_slot_valid, out_last, in_ready} !== 7'b1_0010_1_1) begin errors++; $display("FAIL raw_group1 got=%b exp=1001011", {out_valid, out_slot_valid, out_last, in_ready}); end
        checks++; if (out_s1[7:4] !== 4'h3) begin errors++; $display("FAIL raw_s1 got=%h exp=3", out_s1[7:4]); end
        @(negedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL raw_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        in_valid = 1'b1; in_mask = 4'b0011; out_ready = 1'b0;
        in_instr = {64'h0, 32'h2456_0007, 32'h1312_0005}; #1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            in_instr = {64'h0, 32'h2536_0000, 32'h1312_0005}; #1;
            checks++; if ({out_valid, out_slot_valid, out_last, in_ready, out_des[7:0]} !== {7'b1_0011_1_0, 8'h43}) begin errors++; $display("FAIL bp_hold%0d got=%h", c, {out_valid, out_slot_valid, out_last, in_ready, out_des[7:0]}); end
        end
        @(negedge clk); out_ready = 1'b1; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
        @(negedge clk); in_valid = 1'b0; #1;
        checks++; if ({out_valid, out_slot_valid, out_last, out_des[7:0]} !== {6'b1_0001_0, 8'h53}) begin errors++; $display("FAIL bp_next_bundle got=%h", {out_valid, out_slot_valid, out_last, out_des[7:0]}); end
        @(negedge clk); #1;
        checks++; if ({out_valid, out_slot_valid, out_last} !== 6'b1_0010_1) begin errors++; $display("FAIL bp_next_group1 got=%b exp=100101", {out_valid, out_slot_valid, out_last}); end
        @(negedge clk); #1;
    endtask

    task automatic test_sparse_nop();
        @(negedge clk);
        in_valid = 1'b1; in_mask = 4'b0010; out_ready = 1'b1;
        in_instr = {64'h0, 32'h2456_0007, 32'hFFFF_FFFF}; #1;
        @(negedge clk); in_valid = 1'b0; #1;
        checks++; if ({out_valid, out_slot_valid, out_last, out_des[7:4]} !== {6'b1_0010_1, 4'h4}) begin errors++; $display("FAIL sparse_group got=%h", {out_valid, out_slot_valid, out_last, out_des[7:4]}); end
        @(negedge clk); in_valid = 1'b1; in_mask = 4'b0000; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL empty_mask_accept got=%b exp=1", in_ready); end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); in_valid = 1'b0; #1;
            checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL empty_mask_idle%0d got=%b exp=01", c, {out_valid, in_ready}); end
        end
        @(negedge clk);
        in_valid = 1'b1; in_mask = 4'b0011;
        in_instr = {64'h0, 32'h2536_0000, 32'h0300_0000}; #1;
        @(negedge clk); in_valid = 1'b0; #1;
        checks++; if ({out_valid, out_slot_valid, out_last} !== 6'b1_0011_1) begin errors++; $display("FAIL nop_group got=%b exp=100111", {out_valid, out_slot_valid, out_last}); end
        @(negedge clk); #1;
    endtask

    task automatic test_waw();
        @(negedge clk);
        in_valid = 1'b1; in_mask = 4'b1111; out_ready = 1'b1;
        in_instr = {32'h4500_0000, 32'h3100_0000, 32'h2200_0000, 32'h1100_0000}; #1;
        @(negedge clk); in_valid = 1'b0; #1;
        checks++; if ({out_valid, out_slot_valid, out_last} !== 6'b1_0011_0) begin errors++; $display("FAIL waw_group0 got=%b exp=100110", {out_valid, out_slot_valid, out_last}); end
        @(negedge clk); #1;
        checks++; if ({out_valid, out_slot_valid, out_last} !== 6'b1_1100_1) begin errors++; $display("FAIL waw_group1 got=%b exp=111001", {out_valid, out_slot_valid, out_last}); end
        @(negedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL waw_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        in_valid = 1'b1; in_mask = 4'b0011; out_ready = 1'b1;
        in_instr = {64'h0, 32'h2536_0000, 32'h1312_0005}; #1;
        @(negedge clk); in_valid = 1'b0; #1;
        @(negedge clk); rst = 1'b1; #1;
        checks++; if ({out_slot_valid, in_ready} !== 5'b0010_0) begin errors++; $display("FAIL rstmid_before got=%b exp=00100", {out_slot_valid, in_ready}); end
        @(negedge clk); rst = 1'b0;
        in_valid = 1'b1; in_mask = 4'b0011;
        in_instr = {64'h0, 32'h2456_0007, 32'h1312_0005}; #1;
        checks++; if ({out_valid, out_slot_valid, out_last, in_ready} !== 7'b0_0000_0_1) begin errors++; $display("FAIL rstmid_ctrl got=%b exp=0000001", {out_valid, out_slot_valid, out_last, in_ready}); end
        checks++; if ({out_op, out_des, out_s1, out_s2, out_ime} !== '0) begin errors++; $display("FAIL rstmid_fields got=%h exp=0", {out_op, out_des, out_s1, out_s2, out_ime}); end
        @(negedge clk); in_valid = 1'b0; #1;
        checks++; if ({out_valid, out_slot_valid, out_last, out_des[7:0]} !== {6'b1_0011_1, 8'h43}) begin errors++; $display("FAIL rstmid_fresh got=%h", {out_valid, out_slot_valid, out_last, out_des[7:0]}); end
        @(negedge clk); #1;
    endtask

    task automatic test_random();
        logic [W*32-1:0] cur_ins, nxt_ins;
        logic [W-1:0]    nxt_mask, g;
        logic            exp_rdy;
        cur_ins = '0;
        exp_q.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            out_ready = ($urandom_range(3) != 0);
            for (int i = 0; i < W; i++) begin
                nxt_ins[i*32 +: 32] = {4'($urandom_range(3)), 4'($urandom_range(3)),
                                       4'($urandom_range(3)), 4'($urandom_range(3)), 16'($urandom)};
            end
            nxt_mask = 4'($urandom);
            exp_rdy  = (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
            in_valid = (cyc < 590) && ($urandom_range(3) != 0);
            in_instr = nxt_ins;
            in_mask  = nxt_mask;
            #1;
            checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_rdy); end
            checks++; if (out_valid !== (exp_q.size() != 0)) begin errors++; $display("FAIL rnd_out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_q.size() != 0); end
            if (exp_q.size() != 0) begin
                g = exp_q[0];
                checks++; if ({out_slot_valid, out_last} !== {g, exp_q.size() == 1}) begin errors++; $display("FAIL rnd_group cyc=%0d got=%b/%b exp=%b/%b", cyc, out_slot_valid, out_last, g, exp_q.size() == 1); end
                for (int i = 0; i < W; i++) begin
                    if (g[i]) begin
                        checks++;
                        if ({out_op[i*4 +: 4], out_des[i*4 +: 4], out_s1[i*4 +: 4], out_s2[i*4 +: 4], out_ime[i*5 +: 5]} !==
                            {cur_ins[i*32+16 +: 16], cur_ins[i*32 +: 5]}) begin
                            errors++;
                            $display("FAIL rnd_fields cyc=%0d slot=%0d got=%h exp=%h", cyc, i,
                                     {out_op[i*4 +: 4], out_des[i*4 +: 4], out_s1[i*4 +: 4], out_s2[i*4 +: 4], out_ime[i*5 +: 5]},
                                     {cur_ins[i*32+16 +: 16], cur_ins[i*32 +: 5]});
                        end
                    end
                end
            end
            if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
            if (in_valid && exp_rdy) begin
                cur_ins = nxt_ins;
                model_split(nxt_ins, nxt_mask);
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_raw();
        test_backpressure();
        test_sparse_nop();
        test_waw();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
